// File: rtl/tx_framer.sv
// Transmit framer: prepends a 4-bit sync header to 124-bit payload beats and sends
// training/idle frames so the remote aligner can lock. Optional scrambler: TX_SCRAMBLE_EN.
module tx_framer #(
  parameter int unsigned  TRAIN_CYCLES = 1024,
  parameter int unsigned  IDLE_PERIOD  = 256,
  parameter logic [123:0] IDLE_PAYLOAD = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tx_en,
  input  logic [123:0] s_tdata,
  input  logic         s_tctrl,
  input  logic         s_tvalid,
  output logic         s_tready,
  output logic [127:0] txdata_out,
  output logic         tx_training
);

  localparam logic [3:0]  HDR_CTRL   = 4'b1010;
  localparam logic [3:0]  HDR_DATA   = 4'b0101;
  localparam logic [19:0] TRAIN_LAST = 20'(TRAIN_CYCLES - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(IDLE_PERIOD - 1);
  localparam bit          IDLE_EN    = (IDLE_PERIOD != 0);

  typedef enum logic {
    TRAIN,
    RUN
  } state_t;

  state_t        state, state_next;
  logic [19:0]   train_cnt, train_cnt_next;
  logic [15:0]   idle_cnt, idle_cnt_next;
  logic          idle_slot;
  logic          accept;
  logic [3:0]    header;
  logic [123:0]  payload;
  logic [123:0]  payload_tx;

  // With IDLE_PERIOD=0 the slot compare is constant-false and idle_cnt wraps freely.
  assign idle_slot = IDLE_EN && (idle_cnt == IDLE_LAST);

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_next     = state;
    train_cnt_next = train_cnt;
    idle_cnt_next  = idle_cnt;
    s_tready       = 1'b0;
    if (!tx_en) begin
      state_next     = TRAIN;
      train_cnt_next = '0;
      idle_cnt_next  = '0;
    end else begin
      case (state)
        TRAIN: begin
          if (train_cnt == TRAIN_LAST) begin
            state_next     = RUN;
            train_cnt_next = '0;
          end else begin
            train_cnt_next = train_cnt + 20'd1;
          end
        end
        RUN: begin
          s_tready      = !idle_slot;
          idle_cnt_next = idle_slot ? 16'd0 : idle_cnt + 16'd1;
        end
        default: state_next = TRAIN;
      endcase
    end
  end

  // Anything not accepted this cycle becomes an idle frame.
  always_comb begin
    accept  = s_tvalid && s_tready;
    header  = HDR_CTRL;
    payload = IDLE_PAYLOAD;
    if (accept) begin
      header  = s_tctrl ? HDR_CTRL : HDR_DATA;
      payload = s_tdata;
    end
  end

`ifdef TX_SCRAMBLE_EN
  logic [57:0] scr_state, scr_next;

  // Self-synchronous x^58+x^39+1, MSB first; state holds the previous scrambled bits.
  always_comb begin
    scr_next   = scr_state;
    payload_tx = '0;
    for (int i = 123; i >= 0; i--) begin
      payload_tx[i] = payload[i] ^ scr_next[38] ^ scr_next[57];
      scr_next      = {scr_next[56:0], payload_tx[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) scr_state <= '1;
    else     scr_state <= scr_next;
  end
`else
  assign payload_tx = payload;
`endif

  // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= TRAIN;
      train_cnt   <= '0;
      idle_cnt    <= '0;
      txdata_out  <= {HDR_CTRL, IDLE_PAYLOAD};
      tx_training <= 1'b1;
    end else begin
      state       <= state_next;
      train_cnt   <= train_cnt_next;
      idle_cnt    <= idle_cnt_next;
      txdata_out  <= {header, payload_tx};
      tx_training <= (state_next == TRAIN);
    end
  end

endmodule

// File: tb/tb_tx_framer.sv
// Self-checking bench for tx_framer: directed phases with randomized payloads checked
// against a cycle-counting reference model of the framing rules.
module tb_tx_framer;

  localparam int unsigned  TRAIN_CYCLES = 64;
  localparam int unsigned  IDLE_PERIOD  = 16;
  localparam logic [123:0] IDLE_PL      = {31{4'h6}};
  localparam logic [3:0]   HDR_CTRL     = 4'b1010;
  localparam logic [3:0]   HDR_DATA     = 4'b0101;
  localparam int           NBEATS       = 1000;

  logic         clk = 1'b0;
  logic         rst;
  logic         tx_en;
  logic [123:0] s_tdata;
  logic         s_tctrl;
  logic         s_tvalid;
  logic         s_tready;
  logic [127:0] txdata_out;
  logic         tx_training;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: link state expressed as cycle counts since entering TRAIN/RUN.
  bit           m_run;
  int           m_train;
  int           m_run_cnt;
  logic [127:0] m_tx;
`ifdef TX_SCRAMBLE_EN
  logic [57:0]  m_scr;
`endif

  always #5 clk = ~clk;

  tx_framer #(
    .TRAIN_CYCLES(TRAIN_CYCLES),
    .IDLE_PERIOD (IDLE_PERIOD),
    .IDLE_PAYLOAD(IDLE_PL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .s_tdata    (s_tdata),
    .s_tctrl    (s_tctrl),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .txdata_out (txdata_out),
    .tx_training(tx_training)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [123:0] rand_pl();
    return 124'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  function automatic bit model_ready(input bit en);
    bit slot;
    slot = (IDLE_PERIOD != 0) && ((m_run_cnt % IDLE_PERIOD) == IDLE_PERIOD - 1);
    return en && m_run && !slot;
  endfunction

`ifdef TX_SCRAMBLE_EN
  function automatic logic [123:0] scramble(input logic [123:0] p);
    logic [123:0] o;
    for (int i = 123; i >= 0; i--) begin
      o[i]  = p[i] ^ m_scr[38] ^ m_scr[57];
      m_scr = {m_scr[56:0], o[i]};
    end
    return o;
  endfunction
`endif

  task automatic model_reset();
    m_run     = 1'b0;
    m_train   = 0;
    m_run_cnt = 0;
    m_tx      = {HDR_CTRL, IDLE_PL};
`ifdef TX_SCRAMBLE_EN
    m_scr     = '1;
`endif
  endtask

  // One clock: drive inputs, check s_tready, advance the model, check the registered outputs.
  task automatic step(input bit r, input bit en, input bit v, input bit c,
                      input logic [123:0] d, output bit acc);
    bit           rdy;
    logic [123:0] pl;
    logic [3:0]   hdr;
    rst = r; tx_en = en; s_tvalid = v; s_tctrl = c; s_tdata = d;
    #1;
    rdy = model_ready(en);
    check("s_tready", {127'd0, s_tready}, {127'd0, rdy});
    acc = rdy && v;
    pl  = acc ? d : IDLE_PL;
    hdr = acc ? (c ? HDR_CTRL : HDR_DATA) : HDR_CTRL;
    if (r) begin
      model_reset();
    end else begin
`ifdef TX_SCRAMBLE_EN
      pl = scramble(pl);
`endif
      m_tx = {hdr, pl};
      if (!en) begin
        m_run = 1'b0; m_train = 0; m_run_cnt = 0;
      end else if (!m_run) begin
        m_train++;
        if (m_train == TRAIN_CYCLES) begin
          m_run = 1'b1; m_train = 0; m_run_cnt = 0;
        end
      end else begin
        m_run_cnt++;
      end
    end
    @(posedge clk);
    #1;
    check("txdata_out", txdata_out, m_tx);
    check("tx_training", {127'd0, tx_training}, {127'd0, !m_run});
  endtask

  initial begin
    bit             acc;
    int             k;
    logic [123:0]   q_rx[$];
    logic [123:0]   beat;
    logic [123:0]   d2;

    // Reset: hold 4 cycles, then check reset values.
    rst = 1'b1; tx_en = 1'b1; s_tvalid = 1'b0; s_tctrl = 1'b0; s_tdata = '0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    check("rst_txdata", txdata_out, {HDR_CTRL, IDLE_PL});
    check("rst_tready", {127'd0, s_tready}, 128'd0);
    check("rst_training", {127'd0, tx_training}, 128'd1);

    // Training: 64 cycles of idle with valid beats offered and refused.
    for (int i = 0; i < TRAIN_CYCLES; i++) step(1'b0, 1'b1, 1'b1, 1'($urandom), rand_pl(), acc);
    check("run_training_low", {127'd0, tx_training}, 128'd0);
    #1;
    check("run_tready_high", {127'd0, s_tready}, 128'd1);

    // Directed data and control beats.
    d2 = 124'hABC_DEF0_1234_5678_9ABC_DEF0_4567_0123;
    step(1'b0, 1'b1, 1'b1, 1'b0, d2, acc);
`ifndef TX_SCRAMBLE_EN
    check("data_frame", txdata_out, {HDR_DATA, d2});
`endif
    check("data_hdr", {124'd0, txdata_out[127:124]}, {124'd0, HDR_DATA});
    step(1'b0, 1'b1, 1'b1, 1'b1, d2, acc);
    check("ctrl_hdr", {124'd0, txdata_out[127:124]}, {124'd0, HDR_CTRL});

    // Random traffic with occasional tx_en drops.
    for (int i = 0; i < 300; i++)
      step(1'b0, 1'($urandom_range(0, 59) != 0), 1'($urandom), 1'($urandom), rand_pl(), acc);
    while (!m_run) step(1'b0, 1'b1, 1'b0, 1'b0, '0, acc);

    // Back-to-back incrementing data beats; each is held until accepted.
    k = 0;
    q_rx.delete();
    while (k < NBEATS) begin
      beat = 124'h100_0000 + 124'(k);
      step(1'b0, 1'b1, 1'b1, 1'b0, beat, acc);
      if (acc) k++;
      if (txdata_out[127:124] == HDR_DATA) q_rx.push_back(txdata_out[123:0]);
    end
`ifndef TX_SCRAMBLE_EN
    check("rx_count", 128'(q_rx.size()), 128'(NBEATS));
    for (int i = 0; i < q_rx.size(); i++)
      check("rx_order", {4'd0, q_rx[i]}, {4'd0, 124'h100_0000 + 124'(i)});
`endif

    // tx_en dropped for one cycle mid-stream: beat refused, retrain, then RUN.
    step(1'b0, 1'b1, 1'b1, 1'b0, rand_pl(), acc);
    step(1'b0, 1'b0, 1'b1, 1'b0, rand_pl(), acc);
    check("txen_drop_accept", {127'd0, acc}, 128'd0);
    check("txen_drop_idle", {124'd0, txdata_out[127:124]}, {124'd0, HDR_CTRL});
    for (int i = 0; i < TRAIN_CYCLES; i++) step(1'b0, 1'b1, 1'b1, 1'b0, rand_pl(), acc);
    check("retrain_done", {127'd0, tx_training}, 128'd0);

    // Reset asserted while streaming.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'($urandom), rand_pl(), acc);
    step(1'b1, 1'b1, 1'b1, 1'b0, rand_pl(), acc);
    check("midrst_txdata", txdata_out, {HDR_CTRL, IDLE_PL});
    check("midrst_training", {127'd0, tx_training}, 128'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, rand_pl(), acc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
